add16_rr_arbiter: RTL and testbench

Shares a single 16-bit adder datapath (a + b -> sum) among NREQ requesters using round-robin arbitration. Each requester presents an operand pair with a valid/ready handshake. The granted pair is added and the result is captured in one output register, tagged with the requester id. The block sits between client engines and the shared add16 instance and owns all sequencing of that adder.

---
 rtl/add16_rr_arbiter.sv | 153 +++++++++++++++
 tb/tb_add16_rr_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/add16_rr_arbiter.sv
// -----------------------------------------------------------------------------
// add16_rr_arbiter
//
// Shares one WIDTH-bit adder among NREQ requesters with round-robin priority.
// Each requester offers an operand pair on a valid/ready handshake. The
// granted pair is added (WIDTH+1 bits, carry kept) and captured in a single
// result register tagged with the winning requester index.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   req_valid  [NREQ]        per-requester "operand pair pending"
//   req_ready  [NREQ]        one-hot grant (combinational from req_valid)
//   req_a      [NREQ*WIDTH]  operand a, requester i at [WIDTH*i +: WIDTH]
//   req_b      [NREQ*WIDTH]  operand b, same packing
//   rsp_valid                result register holds an undelivered result
//   rsp_ready                consumer takes the result this cycle
//   rsp_id     [IDW]         requester that owns the result
//   rsp_sum    [WIDTH]       (a + b) mod 2^WIDTH
//   rsp_carry                carry-out of the addition
//   ops_count  [16]          accepted-request counter, wraps
// -----------------------------------------------------------------------------
module add16_rr_arbiter #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic                  rsp_carry,
  output logic [15:0]           ops_count
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [IDW-1:0]   last_grant_reg;
  logic [IDW-1:0]   rsp_id_reg;
  logic [WIDTH-1:0] rsp_sum_reg;
  logic             rsp_carry_reg;
  logic [15:0]      ops_count_reg;

  logic             can_accept;
  logic             grant_found;
  logic [IDW-1:0]   grant_idx;
  logic [IDW-1:0]   search_idx;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [WIDTH:0]   sum_full;

  // Unpack the flat operand buses into per-requester lanes.
  logic [WIDTH-1:0] a_lane [NREQ];
  logic [WIDTH-1:0] b_lane [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_lane
      assign a_lane[gi] = req_a[WIDTH*gi +: WIDTH];
      assign b_lane[gi] = req_b[WIDTH*gi +: WIDTH];
    end
  endgenerate

  // A new pair may enter when the result register is empty, or when it is
  // being drained in this very cycle (gives 1 op/cycle throughput).
  assign can_accept = (state_reg == IDLE) || rsp_ready;

  // Round-robin search: start one past the last winner and walk upward.
  // IDW-bit arithmetic wraps naturally because NREQ == 2**IDW; the final
  // step (k == NREQ) revisits last_grant itself as lowest priority.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    search_idx  = '0;
    if (can_accept && !rst) begin
      for (int k = 1; k <= NREQ; k++) begin
        search_idx = last_grant_reg + k[IDW-1:0];
        if (!grant_found && req_valid[search_idx]) begin
          grant_found = 1'b1;
          grant_idx   = search_idx;
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // Shared adder datapath, fed by the granted lane.
  assign sel_a    = a_lane[grant_idx];
  assign sel_b    = b_lane[grant_idx];
  assign sum_full = {1'b0, sel_a} + {1'b0, sel_b};

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (grant_found) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (grant_found) begin
          state_next = HOLD;
        end else if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      last_grant_reg <= IDW'(NREQ - 1);
      rsp_id_reg     <= '0;
      rsp_sum_reg    <= '0;
      rsp_carry_reg  <= 1'b0;
      ops_count_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (grant_found) begin
        last_grant_reg <= grant_idx;
        rsp_id_reg     <= grant_idx;
        rsp_sum_reg    <= sum_full[WIDTH-1:0];
        rsp_carry_reg  <= sum_full[WIDTH];
        ops_count_reg  <= ops_count_reg + 16'd1;
      end
    end
  end

  assign rsp_valid = (state_reg == HOLD);
  assign rsp_id    = rsp_id_reg;
  assign rsp_sum   = rsp_sum_reg;
  assign rsp_carry = rsp_carry_reg;
  assign ops_count = ops_count_reg;

endmodule

// File: tb/tb_add16_rr_arbiter.sv
// -----------------------------------------------------------------------------
// Self-checking bench for add16_rr_arbiter (WIDTH=16, NREQ=4, IDW=2).
// A behavioural model (last winner, full/empty flag, held result, counter)
// predicts grants and outputs; directed scenarios also use literal values.
// -----------------------------------------------------------------------------
module tb_add16_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_sum;
  logic        rsp_carry;
  logic [15:0] ops_count;

  logic [15:0] a_arr [4];
  logic [15:0] b_arr [4];

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          m_last;
  bit          m_hold;
  int          m_id;
  int unsigned m_sum;
  int          m_carry;
  int unsigned m_ops;

  always #5 clk = ~clk;

  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < 4; i++) begin
      req_a[16*i +: 16] = a_arr[i];
      req_b[16*i +: 16] = b_arr[i];
    end
  end

  add16_rr_arbiter #(.WIDTH(16), .NREQ(4), .IDW(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_carry (rsp_carry),
    .ops_count (ops_count)
  );

  // Expected grant from the arbitration rules: nothing during reset or a
  // stall; otherwise the first pending requester after the last winner.
  function automatic logic [3:0] model_grant();
    logic [3:0] g;
    int idx;
    g = 4'b0000;
    if (!rst && !(m_hold && !rsp_ready)) begin
      for (int k = 1; k <= 4; k++) begin
        idx = (m_last + k) % 4;
        if (req_valid[idx] && g == 4'b0000) g[idx] = 1'b1;
      end
    end
    return g;
  endfunction

  // Drive inputs and let combinational outputs settle (no checks here).
  task automatic apply(input logic [3:0] v, input logic rr);
    req_valid = v;
    rsp_ready = rr;
    #1;
  endtask

  // Advance one clock, updating the model with what the edge should do.
  task automatic tick();
    logic [3:0] g;
    int unsigned s;
    g = model_grant();
    @(posedge clk);
    if (rst) begin
      m_last = 3; m_hold = 0; m_id = 0; m_sum = 0; m_carry = 0; m_ops = 0;
    end else if (g != 4'b0000) begin
      for (int i = 0; i < 4; i++) begin
        if (g[i]) begin
          s       = int'(a_arr[i]) + int'(b_arr[i]);
          m_sum   = s % 65536;
          m_carry = int'(s / 65536);
          m_id    = i;
          m_last  = i;
        end
      end
      m_ops  = (m_ops + 1) % 65536;
      m_hold = 1;
    end else if (m_hold && rsp_ready) begin
      m_hold = 0;
    end
    #1;
  endtask

  task automatic randomize_operands();
    for (int i = 0; i < 4; i++) begin
      a_arr[i] = 16'($urandom);
      b_arr[i] = 16'($urandom);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    apply(4'b1111, 1'b1);
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
    tick();
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", rsp_valid); end
    checks++; if (rsp_id !== 2'd0 || rsp_sum !== 16'd0 || rsp_carry !== 1'b0) begin errors++; $display("FAIL reset_rsp: got id=%0d sum=%0d c=%b expected 0 0 0", rsp_id, rsp_sum, rsp_carry); end
    checks++; if (ops_count !== 16'd0) begin errors++; $display("FAIL reset_ops: got %0d expected 0", ops_count); end
    $display("test_reset: done");
  endtask

  task automatic test_single();
    rst = 1'b0;
    a_arr[2] = 16'd1000; b_arr[2] = 16'd234;
    apply(4'b0100, 1'b1);
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_grant: got %b expected 0100", req_ready); end
    tick();
    apply(4'b0000, 1'b1);
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2) begin errors++; $display("FAIL single_rsp: got v=%b id=%0d expected 1 2", rsp_valid, rsp_id); end
    checks++; if (rsp_sum !== 16'd1234 || rsp_carry !== 1'b0) begin errors++; $display("FAIL single_sum: got %0d c=%b expected 1234 0", rsp_sum, rsp_carry); end
    checks++; if (ops_count !== 16'd1) begin errors++; $display("FAIL single_ops: got %0d expected 1", ops_count); end
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_drain: got %b expected 0", rsp_valid); end
    $display("test_single: sum=%0d", rsp_sum);
  endtask

  task automatic test_overflow();
    a_arr[0] = 16'hFFFF; b_arr[0] = 16'h0002;
    apply(4'b0001, 1'b1);
    tick();
    checks++; if (rsp_sum !== 16'h0001 || rsp_carry !== 1'b1 || rsp_id !== 2'd0) begin errors++; $display("FAIL ovf_0: got sum=%h c=%b id=%0d expected 0001 1 0", rsp_sum, rsp_carry, rsp_id); end
    a_arr[1] = 16'h8000; b_arr[1] = 16'h8000;
    apply(4'b0010, 1'b1);
    tick();
    checks++; if (rsp_sum !== 16'h0000 || rsp_carry !== 1'b1 || rsp_id !== 2'd1) begin errors++; $display("FAIL ovf_1: got sum=%h c=%b id=%0d expected 0000 1 1", rsp_sum, rsp_carry, rsp_id); end
    apply(4'b0000, 1'b1);
    tick();
    $display("test_overflow: done");
  endtask

  task automatic test_round_robin();
    int exp_seq [6] = '{0, 1, 2, 3, 0, 1};
    rst = 1'b1; apply(4'b0000, 1'b1); tick(); rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      randomize_operands();
      apply(4'b1111, 1'b1);
      checks++; if (req_ready !== (4'b0001 << exp_seq[c])) begin errors++; $display("FAIL rr_grant%0d: got %b expected idx %0d", c, req_ready, exp_seq[c]); end
      tick();
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(exp_seq[c]) || ops_count !== 16'(c + 1) || rsp_sum !== 16'(m_sum)) begin
        errors++; $display("FAIL rr_rsp%0d: got v=%b id=%0d ops=%0d sum=%h expected 1 %0d %0d %h", c, rsp_valid, rsp_id, ops_count, rsp_sum, exp_seq[c], c + 1, m_sum);
      end
      $display("test_round_robin: cycle %0d grant %0d", c, rsp_id);
    end
  endtask

  // Continues from round-robin: result held, last winner is 1.
  task automatic test_backpressure();
    logic [15:0] held_sum;
    logic [1:0]  held_id;
    held_sum = rsp_sum; held_id = rsp_id;
    for (int c = 0; c < 3; c++) begin
      randomize_operands();
      apply(4'b1111, 1'b0);
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready%0d: got %b expected 0000", c, req_ready); end
      tick();
      checks++; if (rsp_valid !== 1'b1 || rsp_sum !== held_sum || rsp_id !== held_id) begin errors++; $display("FAIL bp_hold%0d: got v=%b sum=%h id=%0d expected 1 %h %0d", c, rsp_valid, rsp_sum, rsp_id, held_sum, held_id); end
    end
    apply(4'b1111, 1'b1);
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_resume: got %b expected 0100", req_ready); end
    tick();
    checks++; if (rsp_id !== 2'd2 || rsp_sum !== 16'(m_sum)) begin errors++; $display("FAIL bp_result: got id=%0d sum=%h expected 2 %h", rsp_id, rsp_sum, m_sum); end
    $display("test_backpressure: done");
  endtask

  task automatic test_skip_priority();
    rst = 1'b1; apply(4'b0000, 1'b1); tick(); rst = 1'b0;
    apply(4'b0010, 1'b1); tick();
    apply(4'b0001, 1'b1);
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL skip_wrap: got %b expected 0001", req_ready); end
    tick();
    apply(4'b1011, 1'b1);
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL skip_g1: got %b expected 0010", req_ready); end
    tick();
    apply(4'b1011, 1'b1);
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL skip_g3: got %b expected 1000", req_ready); end
    tick();
    apply(4'b0000, 1'b1); tick(); tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL skip_idle: got %b expected 0", rsp_valid); end
    apply(4'b1111, 1'b1);
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL skip_noRotate: got %b expected 0001", req_ready); end
    tick();
    $display("test_skip_priority: done");
  endtask

  task automatic test_reset_mid();
    apply(4'b0100, 1'b0); tick();
    rst = 1'b1;
    apply(4'b1111, 1'b0);
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL mid_ready: got %b expected 0000", req_ready); end
    tick();
    rst = 1'b0;
    apply(4'b1111, 1'b1);
    checks++; if (rsp_valid !== 1'b0 || ops_count !== 16'd0) begin errors++; $display("FAIL mid_state: got v=%b ops=%0d expected 0 0", rsp_valid, ops_count); end
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_first: got %b expected 0001", req_ready); end
    tick();
    $display("test_reset_mid: done");
  endtask

  task automatic test_random();
    logic [3:0] g;
    for (int c = 0; c < 400; c++) begin
      randomize_operands();
      apply(4'($urandom), ($urandom_range(0, 9) < 7));
      g = model_grant();
      checks++; if (req_ready !== g) begin errors++; $display("FAIL rand_grant%0d: got %b expected %b", c, req_ready, g); end
      tick();
      checks++; if (rsp_valid !== m_hold || rsp_id !== 2'(m_id) || rsp_sum !== 16'(m_sum) || rsp_carry !== 1'(m_carry) || ops_count !== 16'(m_ops)) begin
        errors++; $display("FAIL rand_rsp%0d: got v=%b id=%0d sum=%h c=%b ops=%0d expected %b %0d %h %0d %0d", c, rsp_valid, rsp_id, rsp_sum, rsp_carry, ops_count, m_hold, m_id, m_sum, m_carry, m_ops);
      end
    end
    $display("test_random: done, ops=%0d", ops_count);
  endtask

  task automatic test_wrap();
    int guard = 0;
    while (m_ops != 65535 && guard < 70000) begin
      apply(4'b1111, 1'b1); tick(); guard++;
    end
    checks++; if (ops_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_max: got %h expected ffff", ops_count); end
    apply(4'b1111, 1'b1); tick();
    checks++; if (ops_count !== 16'h0000) begin errors++; $display("FAIL wrap_zero: got %h expected 0000", ops_count); end
    apply(4'b0000, 1'b1); tick();
    $display("test_wrap: done");
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin a_arr[i] = '0; b_arr[i] = '0; end
    m_last = 3; m_hold = 0; m_id = 0; m_sum = 0; m_carry = 0; m_ops = 0;
    @(negedge clk);
    test_reset();
    test_single();
    test_overflow();
    test_round_robin();
    test_backpressure();
    test_skip_priority();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
